bnn_mem_seq: RTL
================

Name: bnn_mem_seq

Overview:
Parametrised BNN buffer access sequencer that generalises the fixed 36-word image read counter. It produces programmable base/length/stride address sweeps, in read or write mode, repeated over several passes. It honours a downstream stall and reports busy, last-word and done status. It sits between the SPI wrapper control registers and the single-port image/weight buffers.

Parameters:
AW, 6, address/index width; buffer depth 2^AW words
SW, 3, stride width; stride zero-extended to AW
PW, 4, pass-count width
GAP, 0, idle cycles inserted between passes (0..15); GAP=0 means back-to-back passes

Ports:
iCLK  in  1  clock, rising edge
iRSTn  in  1  asynchronous active-low reset
iCLR  in  1  synchronous clear, highest priority after reset
iSTART  in  1  start request, sampled only in IDLE
iMODE  in  1  0=read sweep, 1=write sweep; captured at start
iBASE  in  AW  first address; captured at start
iLEN  in  AW  words per pass minus 1; captured at start
iSTRIDE  in  SW  address increment per word; captured at start
iPASSES  in  PW  passes minus 1; captured at start
iSTALL  in  1  1 = downstream not ready; suppresses access this cycle
oADDR  out  AW  registered buffer address
oRd_EN  out  1  read strobe, combinational from state, mode and iSTALL
oWr_EN  out  1  write strobe, combinational from state, mode and iSTALL
oIDX  out  AW  word index within current pass
oPASS  out  PW  current pass number
oLAST  out  1  1 while oIDX==len_q in RUN
oBUSY  out  1  state != IDLE
oDONE  out  1  one-cycle pulse at sweep end

Behaviour:
- Reset (async, iRSTn=0): state IDLE; oADDR, oIDX and oPASS are 0; all captured config regs are 0; oRd_EN=oWr_EN=oLAST=oBUSY=oDONE=0.
- iCLR=1 at an edge: state goes to IDLE and counters go to 0 from any state. No oDONE pulse. Applies mid-sweep.
- States: IDLE, RUN, GAP, DONE.
- IDLE: on iSTART=1, capture mode_q, base_q, len_q, stride_q and passes_q; load oADDR=iBASE, oIDX=0, oPASS=0; go to RUN. iSTART in any other state is ignored.
- RUN: acc = ~iSTALL. oRd_EN = acc & ~mode_q; oWr_EN = acc & mode_q. Exactly one strobe may be high.
- On an edge with acc=1 and oIDX<len_q: oIDX+1; oADDR = oADDR+stride_q, modulo 2^AW (wrap silently).
- On an edge with acc=1 and oIDX==len_q:
  - If oPASS==passes_q: go to DONE.
  - Otherwise: oPASS+1, oIDX=0, oADDR=base_q, and go to GAP (GAP>0) or stay in RUN (GAP=0).
- iSTALL=1 in RUN: oADDR, oIDX and oPASS hold, strobes are 0, no state change.
- GAP: a counter counts GAP cycles with strobes 0, then returns to RUN. iSTALL is ignored in GAP.
- DONE: oDONE=1 for exactly one cycle, then go to IDLE. oADDR holds the last address. A new iSTART is accepted from the following IDLE cycle.
- Latency: iSTART sampled at edge k, first strobe in the cycle after edge k, oADDR=base.
- Total unstalled strobe cycles = (len_q+1)*(passes_q+1). Total busy cycles = strobe cycles + passes_q*GAP + 1 (DONE).
- stride_q=0 is legal: the same address is repeated len_q+1 times.
- len_q=0: a single word per pass, and oLAST is high on every RUN cycle.
- Simultaneous iCLR and iSTART: iCLR wins, and the block stays IDLE.

Test Plan:
- Legacy sweep: base=0, len=35, stride=1, passes=0, mode=0, no stall -> oRd_EN high 36 cycles, oADDR 0..35, oLAST at 35, oDONE one cycle later, oWr_EN always 0.
- Stride and wrap: AW=6, base=60, len=4, stride=3, mode=1 -> oWr_EN 5 cycles, oADDR 60,63,2,5,8; oRd_EN always 0.
- Multi-pass with gap: GAP=2, base=8, len=2, passes=2 -> addresses 8,9,10 three times, oPASS 0/1/2, two strobe-free cycles between passes, 9 strobes total, busy 14 cycles.
- Stall: stall asserted for 3 cycles while oIDX=5 -> oADDR/oIDX hold, no strobes during stall, sweep completes with exactly len+1 strobes.
- Clear mid-sweep: iCLR at oIDX=10 -> next cycle IDLE, oADDR=0, oBUSY=0, no oDONE; a following iSTART restarts cleanly from iBASE.
- Reset and ignored start: iRSTn low mid-RUN -> all outputs 0 immediately; iSTART pulsed during RUN -> no restart, the original sweep continues.

Source files
------------

// File: rtl/bnn_mem_seq.sv
// Programmable base/length/stride buffer sweep sequencer with multi-pass repeat and optional inter-pass gap.
// Strobes are combinational from state/mode/iSTALL; address and counters are registered and hold while stalled.
module bnn_mem_seq #(
  parameter int AW  = 6,
  parameter int SW  = 3,
  parameter int PW  = 4,
  parameter int GAP = 0
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iCLR,
  input  logic          iSTART,
  input  logic          iMODE,
  input  logic [AW-1:0] iBASE,
  input  logic [AW-1:0] iLEN,
  input  logic [SW-1:0] iSTRIDE,
  input  logic [PW-1:0] iPASSES,
  input  logic          iSTALL,
  output logic [AW-1:0] oADDR,
  output logic          oRd_EN,
  output logic          oWr_EN,
  output logic [AW-1:0] oIDX,
  output logic [PW-1:0] oPASS,
  output logic          oLAST,
  output logic          oBUSY,
  output logic          oDONE
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

  // GAP=0 never enters S_GAP, so the terminal count value is irrelevant there.
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t        state_q;
  logic          mode_q;
  logic [AW-1:0] base_q;
  logic [AW-1:0] len_q;
  logic [SW-1:0] stride_q;
  logic [PW-1:0] passes_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] idx_q;
  logic [PW-1:0] pass_q;
  logic [3:0]    gap_cnt_q;
  logic          acc;

  assign acc = (state_q == S_RUN) && !iSTALL;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      stride_q  <= '0;
      passes_q  <= '0;
      addr_q    <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      gap_cnt_q <= '0;
    end else if (iCLR) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      gap_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iSTART) begin
            mode_q   <= iMODE;
            base_q   <= iBASE;
            len_q    <= iLEN;
            stride_q <= iSTRIDE;
            passes_q <= iPASSES;
            addr_q   <= iBASE;
            idx_q    <= '0;
            pass_q   <= '0;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          if (acc) begin
            if (idx_q < len_q) begin
              idx_q  <= idx_q + 1'b1;
              addr_q <= addr_q + AW'(stride_q);
            end else if (pass_q == passes_q) begin
              state_q <= S_DONE;
            end else begin
              pass_q <= pass_q + 1'b1;
              idx_q  <= '0;
              addr_q <= base_q;
              if (GAP > 0) begin
                state_q   <= S_GAP;
                gap_cnt_q <= '0;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= S_RUN;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oADDR  = addr_q;
  assign oIDX   = idx_q;
  assign oPASS  = pass_q;
  assign oRd_EN = acc && !mode_q;
  assign oWr_EN = acc && mode_q;
  assign oLAST  = (state_q == S_RUN) && (idx_q == len_q);
  assign oBUSY  = (state_q != S_IDLE);
  assign oDONE  = (state_q == S_DONE);

endmodule
